// File: rtl/dual_port_ram.sv
// Byte-addressed dual-port RAM: port A returns wide instruction lines, port B serves 32-bit data.
// Define DP_RAM_X_CHECK_EN to add simulation-only X checks on the access controls.
module dual_port_ram #(
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned INSTR_RDATA_WIDTH = 128
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_a_i,
  input  logic [ADDR_WIDTH-1:0]        addr_a_i,
  input  logic [31:0]                  wdata_a_i,
  output logic [INSTR_RDATA_WIDTH-1:0] rdata_a_o,
  input  logic                         we_a_i,
  input  logic [3:0]                   be_a_i,
  input  logic                         en_b_i,
  input  logic [ADDR_WIDTH-1:0]        addr_b_i,
  input  logic [31:0]                  wdata_b_i,
  output logic [31:0]                  rdata_b_o,
  input  logic                         we_b_i,
  input  logic [3:0]                   be_b_i
);

  localparam int unsigned LINE_BYTES = INSTR_RDATA_WIDTH / 8;
  localparam int unsigned MEM_BYTES  = 2 ** ADDR_WIDTH;

  logic [7:0]                   mem_q [MEM_BYTES];
  logic [INSTR_RDATA_WIDTH-1:0] rdata_a_q;
  logic [31:0]                  rdata_b_q;

  logic [ADDR_WIDTH-1:0] addr_a_al;
  logic [ADDR_WIDTH-1:0] addr_b_al;
  logic                  rd_a, wr_a, rd_b, wr_b;

  // Masking rather than slicing keeps every address bit in use.
  assign addr_a_al = addr_a_i & ~ADDR_WIDTH'(3);
  assign addr_b_al = addr_b_i & ~ADDR_WIDTH'(3);

  assign rd_a = en_a_i & ~we_a_i;
  assign wr_a = en_a_i &  we_a_i;
  assign rd_b = en_b_i & ~we_b_i;
  assign wr_b = en_b_i &  we_b_i;

  // NOTE: non-blocking writes mean every read in this block sees the pre-edge
  // contents, which gives read-before-write; the port B write is issued last so
  // it wins a same-byte collision.
  // NOTE: the storage array is deliberately left out of the reset branch; only
  // its write enable is gated by reset, so it can still map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (rd_a) begin
        for (int i = 0; i < LINE_BYTES; i++) begin
          rdata_a_q[8*i +: 8] <= mem_q[addr_a_al + ADDR_WIDTH'(i)];
        end
      end
      if (rd_b) begin
        for (int i = 0; i < 4; i++) begin
          rdata_b_q[8*i +: 8] <= mem_q[addr_b_al + ADDR_WIDTH'(i)];
        end
      end
      if (wr_a) begin
        for (int k = 0; k < 4; k++) begin
          if (be_a_i[k]) mem_q[addr_a_al + ADDR_WIDTH'(k)] <= wdata_a_i[8*k +: 8];
        end
      end
      if (wr_b) begin
        for (int k = 0; k < 4; k++) begin
          if (be_b_i[k]) mem_q[addr_b_al + ADDR_WIDTH'(k)] <= wdata_b_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

`ifdef DP_RAM_X_CHECK_EN
  always @(posedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (INSTR_RDATA_WIDTH % 32 != 0)
        $error("dual_port_ram: INSTR_RDATA_WIDTH %0d is not a multiple of 32", INSTR_RDATA_WIDTH);
      if ($isunknown(en_a_i)) $error("dual_port_ram: en_a_i is X");
      if ($isunknown(en_b_i)) $error("dual_port_ram: en_b_i is X");
      if (en_a_i === 1'b1) begin
        if ($isunknown({addr_a_i, we_a_i, be_a_i})) $error("dual_port_ram: X on port A controls");
        if (we_a_i === 1'b1 && $isunknown(wdata_a_i)) $error("dual_port_ram: X on wdata_a_i");
      end
      if (en_b_i === 1'b1) begin
        if ($isunknown({addr_b_i, we_b_i, be_b_i})) $error("dual_port_ram: X on port B controls");
        if (we_b_i === 1'b1 && $isunknown(wdata_b_i)) $error("dual_port_ram: X on wdata_b_i");
      end
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram with hand-computed expected values.
module tb_dual_port_ram;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 128;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_a_i, we_a_i, en_b_i, we_b_i;
  logic [AW-1:0] addr_a_i, addr_b_i;
  logic [31:0]   wdata_a_i, wdata_b_i;
  logic [3:0]    be_a_i, be_b_i;
  logic [IW-1:0] rdata_a_o;
  logic [31:0]   rdata_b_o;

  int n_cmp = 0;
  int n_err = 0;

  dual_port_ram #(.ADDR_WIDTH(AW), .INSTR_RDATA_WIDTH(IW)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_a_i    (en_a_i),
    .addr_a_i  (addr_a_i),
    .wdata_a_i (wdata_a_i),
    .rdata_a_o (rdata_a_o),
    .we_a_i    (we_a_i),
    .be_a_i    (be_a_i),
    .en_b_i    (en_b_i),
    .addr_b_i  (addr_b_i),
    .wdata_b_i (wdata_b_i),
    .rdata_b_o (rdata_b_o),
    .we_b_i    (we_b_i),
    .be_b_i    (be_b_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    en_a_i = 1'b0; we_a_i = 1'b0; addr_a_i = '0; wdata_a_i = '0; be_a_i = '0;
    en_b_i = 1'b0; we_b_i = 1'b0; addr_b_i = '0; wdata_b_i = '0; be_b_i = '0;
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    en_b_i = 1'b1; we_b_i = we; addr_b_i = a; wdata_b_i = d; be_b_i = be;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    en_a_i = 1'b1; we_a_i = we; addr_a_i = a; wdata_a_i = d; be_a_i = be;
  endtask

  task automatic write_b(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    idle(); set_b(1'b1, a, d, be); step(); idle();
  endtask

  initial begin
    idle();
    rst_ni = 1'b1;

    // Known content at 0x10 before reset, so a dropped reset-cycle write is visible.
    write_b(16'h0010, 32'h0123_4567, 4'hF);

    // Reset held for two edges with a full-word write presented on port B.
    rst_ni = 1'b0;
    set_b(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_rdata_a", rdata_a_o, '0);
      check("rst_rdata_b", {96'd0, rdata_b_o}, 128'd0);
    end
    rst_ni = 1'b1;
    idle();
    set_b(1'b0, 16'h0010, '0, '0);
    step();
    check("rst_write_dropped", {96'd0, rdata_b_o}, {96'd0, 32'h0123_4567});
    check("rst_a_hold", rdata_a_o, '0);
    idle();

    // Byte-enabled writes, then an unaligned read address.
    write_b(16'h0100, 32'h1122_3344, 4'hF);
    check("b_write_holds_rdata", {96'd0, rdata_b_o}, {96'd0, 32'h0123_4567});
    write_b(16'h0100, 32'hAABB_CCDD, 4'h5);
    set_b(1'b0, 16'h0102, '0, '0);
    step();
    check("be_merge_aligned", {96'd0, rdata_b_o}, {96'd0, 32'h11BB_33DD});
    idle();

    // Idle port B: both read outputs must hold.
    for (int c = 0; c < 3; c++) begin
      step();
      check("b_idle_hold", {96'd0, rdata_b_o}, {96'd0, 32'h11BB_33DD});
    end
    check("a_idle_hold", rdata_a_o, '0);

    // Wide fetch from an unaligned port A address.
    for (int w = 0; w < 4; w++) write_b(AW'(32 + 4 * w), 32'(w), 4'hF);
    set_a(1'b0, 16'h0022, '0, '0);
    step();
    check("wide_fetch", rdata_a_o, {32'h3, 32'h2, 32'h1, 32'h0});
    idle();

    // Line wraps past the top of memory.
    write_b(16'hFFFC, 32'hCAFE_F00D, 4'hF);
    write_b(16'h0000, 32'h1234_5678, 4'hF);
    set_a(1'b0, 16'hFFFC, '0, '0);
    step();
    check("wrap_lo", {96'd0, rdata_a_o[31:0]}, {96'd0, 32'hCAFE_F00D});
    check("wrap_hi", {96'd0, rdata_a_o[63:32]}, {96'd0, 32'h1234_5678});
    idle();

    // Cross-port read-before-write.
    write_b(16'h0040, 32'h0101_0101, 4'hF);
    set_b(1'b1, 16'h0040, 32'h5555_5555, 4'hF);
    set_a(1'b0, 16'h0040, '0, '0);
    step();
    check("xport_old_data", {96'd0, rdata_a_o[31:0]}, {96'd0, 32'h0101_0101});
    set_b(1'b0, 16'h0040, '0, '0);
    step();
    check("xport_new_a", {96'd0, rdata_a_o[31:0]}, {96'd0, 32'h5555_5555});
    check("xport_new_b", {96'd0, rdata_b_o}, {96'd0, 32'h5555_5555});
    idle();

    // Both ports write byte 0x200; port B must win.
    set_a(1'b1, 16'h0200, 32'h0000_00AA, 4'h1);
    set_b(1'b1, 16'h0200, 32'h0000_00BB, 4'h1);
    step();
    idle();
    set_b(1'b0, 16'h0200, '0, '0);
    step();
    check("collision_b_wins", {120'd0, rdata_b_o[7:0]}, {120'd0, 8'hBB});
    idle();

    // Port A write path, observed through port B.
    set_a(1'b1, 16'h0205, 32'hA5C3_9617, 4'hF);
    step();
    idle();
    set_b(1'b0, 16'h0204, '0, '0);
    step();
    check("a_write", {96'd0, rdata_b_o}, {96'd0, 32'hA5C3_9617});

    // Mid-operation reset drops the presented read and clears both outputs.
    rst_ni = 1'b0;
    set_a(1'b0, 16'h0040, '0, '0);
    set_b(1'b0, 16'h0204, '0, '0);
    step();
    check("midrst_a", rdata_a_o, '0);
    check("midrst_b", {96'd0, rdata_b_o}, 128'd0);
    rst_ni = 1'b1;
    idle();
    step();
    check("post_rst_hold_b", {96'd0, rdata_b_o}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Byte-addressed, dual-port synchronous RAM that is the memory behind the core testbench's memory-mapped wrapper. Port A serves instruction fetches as a wide read-only line of INSTR_RDATA_WIDTH bits. Port B serves the data interface with 32-bit reads and byte-enabled writes. Both ports share one clock and one storage array, and each port reads with a fixed one-cycle latency.

## Interface
Parameters:
- ADDR_WIDTH, default 16: byte-address width; storage is 2^ADDR_WIDTH bytes.
- INSTR_RDATA_WIDTH, default 128: port A read width in bits; a multiple of 32, at least 32.

Ports:
- clk_i  in  1  clock; all activity on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- en_a_i  in  1  port A access enable.
- addr_a_i  in  ADDR_WIDTH  port A byte address.
- wdata_a_i  in  32  port A write data.
- rdata_a_o  out  INSTR_RDATA_WIDTH  port A read data.
- we_a_i  in  1  port A write enable.
- be_a_i  in  4  port A byte enables.
- en_b_i  in  1  port B access enable.
- addr_b_i  in  ADDR_WIDTH  port B byte address.
- wdata_b_i  in  32  port B write data.
- rdata_b_o  out  32  port B read data.
- we_b_i  in  1  port B write enable.
- be_b_i  in  4  port B byte enables.

## Operation
- Storage is an array of 2^ADDR_WIDTH bytes. Reset does not clear or initialise it. Simulation may preload it by hierarchical access or $readmemh.
- Both ports align their address to a word by forcing addr[1:0] to 0.
- Port A read (en_a_i=1, we_a_i=0): returns INSTR_RDATA_WIDTH/8 consecutive bytes starting at the aligned address. Byte i of the line goes to rdata_a_o[8i+7:8i], so the result is little-endian.
- Port A line addresses wrap modulo 2^ADDR_WIDTH when the line crosses the top of memory.
- Port A write (en_a_i=1, we_a_i=1): writes byte k of wdata_a_i to aligned+k for every be_a_i[k]=1, with k from 0 to 3.
- Port B read: returns the 4 bytes at the aligned address, little-endian, on rdata_b_o.
- Port B write: byte-enabled exactly like a port A write.
- Any port with en=0 performs no access.
- A port's rdata holds its previous value in every cycle with no read on that port: en=0, a write cycle, or reset released.
- Read-during-write on any port or either pair returns old data (read-before-write).
- Both ports writing the same byte in the same cycle: the port B value is stored.
- Reset (rst_ni=0 at a rising edge): rdata_a_o and rdata_b_o go to 0 and all accesses that cycle are ignored, including writes.
- Reset is honoured mid-operation. An access presented on the reset edge is dropped.

## Timing
- Read latency is exactly 1 cycle. With en=1 and we=0 at edge N, rdata is valid after edge N and holds until the next read on that port.
- Writes take effect at the edge where en=1 and we=1. A read issued at the next edge sees the new data.
- There is no handshake or backpressure. Every enabled access completes; the wrapper drives gnt=req and rvalid=req delayed by one cycle.
- Reset values: rdata_a_o = 0, rdata_b_o = 0.

## Configuration
- DP_RAM_X_CHECK_EN, when defined, adds simulation-only checks:
  - $error if en_a_i or en_b_i is X.
  - $error if an enabled port has an X bit in addr, we, or be (and wdata when writing).
  - $error if INSTR_RDATA_WIDTH is not a multiple of 32.
- The checks are evaluated at each rising edge while rst_ni=1.
- When not defined, no checks exist. Functional behaviour is identical in both builds.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles with en_b_i=1, we_b_i=1, addr 0x10, data 0xDEADBEEF, be 0xF. Then release and read addr 0x10. Required: rdata_a_o=0 and rdata_b_o=0 during reset, and the reset-cycle write is not stored.
- Byte enables: write port B addr 0x100 data 0x11223344 be 0xF, then data 0xAABBCCDD be 0x5. Then read addr 0x102. Required: the read uses the aligned address and rdata_b_o=0x11BB33DD one cycle later.
- Wide fetch: write words 0x0, 0x1, 0x2, 0x3 at addresses 0x20, 0x24, 0x28, 0x2C, then read port A at 0x22 (aligned to 0x20). Required: rdata_a_o=0x00000003_00000002_00000001_00000000.
- Wrap: with ADDR_WIDTH=16, write 0xCAFEF00D at 0xFFFC and 0x12345678 at 0x0000, then read port A at 0xFFFC. Required: rdata_a_o[31:0]=0xCAFEF00D and rdata_a_o[63:32]=0x12345678.
- Cross-port read-before-write: the same cycle has a port B write of 0x55555555 to 0x40 and a port A read of 0x40 (old value 0x01010101). Required: rdata_a_o[31:0]=0x01010101, and a read on the next cycle returns 0x55555555.
- Hold and collision: after rdata_b_o=0x11BB33DD, idle port B for 3 cycles. Then have both ports write byte 0x200 with A=0xAA and B=0xBB. Required: rdata_b_o holds its value while idle, and the later read of 0x200 returns 0xBB in byte 0.
